// File: rtl/conv_pkg.sv
// Shared types and constants for the conv job transmitter.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILT  = 3'd1,
    ST_GAP   = 3'd2,
    ST_IMG   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Tag carried alongside each memory read so the beat lands on the right strobe.
  typedef enum logic [1:0] {
    BEAT_NONE = 2'd0,
    BEAT_FILT = 2'd1,
    BEAT_IMG  = 2'd2
  } beat_t;

  localparam logic [6:0] TAPS_3X3 = 7'd9;
  localparam logic [6:0] TAPS_5X5 = 7'd25;
  localparam logic [3:0] IMG_MIN  = 4'd3;
  localparam logic [3:0] IMG_MAX  = 4'd8;

  function automatic logic [6:0] tap_count(input logic fs);
    return fs ? TAPS_5X5 : TAPS_3X3;
  endfunction

  // N*N fits in 7 bits for every legal N (max 64).
  function automatic logic [6:0] pix_count(input logic [3:0] n);
    logic [6:0] w;
    w = {3'b000, n};
    return w * w;
  endfunction

  function automatic logic size_legal(input logic [3:0] n);
    return (n >= IMG_MIN) && (n <= IMG_MAX);
  endfunction

endpackage

// File: rtl/conv_job_tx_if.sv
// Bundle of job, memory and engine signals around the conv job transmitter.
// Handshake semantics: there is no ready anywhere. start is a one-cycle
// request honoured only while busy is low; done/err are one-cycle pulses;
// mem_rd is a read strobe whose data returns on mem_rdata exactly one cycle
// later; filter_valid/image_valid/out_valid are strobes whose data (if any)
// is valid in the same cycle and which the receiver must take unconditionally.
interface conv_job_tx_if #(
  parameter int ADDR_W = 7
);
  logic                start;
  logic                start_filter_size;
  logic [3:0]          start_image_size;
  logic                start_pad_mode;
  logic                start_act_mode;
  logic                busy;
  logic                done;
  logic                err;
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic signed [7:0]   mem_rdata;
  logic                filter_valid;
  logic                image_valid;
  logic                filter_size;
  logic [3:0]          image_size;
  logic                pad_mode;
  logic                act_mode;
  logic signed [7:0]   in_data;
  logic                out_valid;

  modport master (
    input  start, start_filter_size, start_image_size, start_pad_mode,
           start_act_mode, mem_rdata, out_valid,
    output busy, done, err, mem_rd, mem_addr, filter_valid, image_valid,
           filter_size, image_size, pad_mode, act_mode, in_data
  );

  modport slave (
    output start, start_filter_size, start_image_size, start_pad_mode,
           start_act_mode, mem_rdata, out_valid,
    input  busy, done, err, mem_rd, mem_addr, filter_valid, image_valid,
           filter_size, image_size, pad_mode, act_mode, in_data
  );
endinterface

// File: rtl/conv_rd_pipe.sv
// Two-stage pipe: read strobe/tag -> (memory latency) -> registered beat.
module conv_rd_pipe
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_i,
  input  beat_t             tag_i,
  input  logic signed [7:0] rdata_i,
  output logic              filter_valid_o,
  output logic              image_valid_o,
  output logic signed [7:0] data_o
);

  beat_t             s1_tag_q;
  logic              fv_q;
  logic              iv_q;
  logic signed [7:0] data_q;

  // Stage 1: tag follows the read strobe so it lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) s1_tag_q <= BEAT_NONE;
    else     s1_tag_q <= rd_i ? tag_i : BEAT_NONE;
  end

  // Stage 2: register the returned byte and decode the tag into strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q   <= 1'b0;
      iv_q   <= 1'b0;
      data_q <= '0;
    end else begin
      fv_q   <= (s1_tag_q == BEAT_FILT);
      iv_q   <= (s1_tag_q == BEAT_IMG);
      data_q <= (s1_tag_q != BEAT_NONE) ? rdata_i : '0;
    end
  end

  assign filter_valid_o = fv_q;
  assign image_valid_o  = iv_q;
  assign data_o         = data_q;

endmodule

// File: rtl/conv_job_tx.sv
// Job transmitter: fetches taps then pixels, streams them to the engine with
// a single idle cycle between bursts, then waits for the engine's results.
module conv_job_tx
  import conv_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int FILT_BASE = 0,
  parameter int IMG_BASE  = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic          clk,
  input  logic          rst,
  conv_job_tx_if.master bus,
  output state_t        dbg_state_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [6:0]          idx_q, idx_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rd_q, rd_d;
  beat_t               tag_q, tag_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rej_q, rej_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                fs_q, pad_q, act_q;
  logic [3:0]          n_q;
  logic                accept;
  logic [6:0]          taps;
  logic [6:0]          npix;

  assign taps = tap_count(fs_q);
  assign npix = pix_count(n_q);

  // Next-state and registered-output decode. Reads are issued one cycle after
  // the state that requests them, which creates the GAP read slot naturally.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_d    = 1'b0;
    tag_d   = BEAT_NONE;
    addr_d  = '0;
    accept  = 1'b0;
    rej_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = rej_q;   // an illegal descriptor reports one cycle after rejection
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (size_legal(bus.start_image_size)) begin
            accept  = 1'b1;
            idx_d   = '0;
            state_d = ST_FILT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_FILT: begin
        rd_d   = 1'b1;
        tag_d  = BEAT_FILT;
        addr_d = ADDR_W'(FILT_BASE) + ADDR_W'(idx_q);
        if (idx_q == taps - 7'd1) begin
          idx_d   = '0;
          state_d = ST_GAP;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IMG;
      end
      ST_IMG: begin
        rd_d   = 1'b1;
        tag_d  = BEAT_IMG;
        addr_d = ADDR_W'(IMG_BASE) + ADDR_W'(idx_q);
        if (idx_q == npix - 7'd1) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q >= npix) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result and timeout counters.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)                                   cnt_d = '0;
    else if ((state_q != ST_IDLE) && bus.out_valid) cnt_d = cnt_q + 7'd1;
    tmo_d = (state_q == ST_DRAIN) ? tmo_q + TMO_W'(1) : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rd_q    <= 1'b0;
      tag_q   <= BEAT_NONE;
      addr_q  <= '0;
      rej_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      rej_q   <= rej_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Job configuration, held steady for the whole job.
  always_ff @(posedge clk) begin
    if (rst) begin
      fs_q  <= 1'b0;
      n_q   <= '0;
      pad_q <= 1'b0;
      act_q <= 1'b0;
    end else if (accept) begin
      fs_q  <= bus.start_filter_size;
      n_q   <= bus.start_image_size;
      pad_q <= bus.start_pad_mode;
      act_q <= bus.start_act_mode;
    end
  end

  conv_rd_pipe u_pipe (
    .clk            (clk),
    .rst            (rst),
    .rd_i           (rd_q),
    .tag_i          (tag_q),
    .rdata_i        (bus.mem_rdata),
    .filter_valid_o (bus.filter_valid),
    .image_valid_o  (bus.image_valid),
    .data_o         (bus.in_data)
  );

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.mem_rd      = rd_q;
  assign bus.mem_addr    = addr_q;
  assign bus.filter_size = fs_q;
  assign bus.image_size  = n_q;
  assign bus.pad_mode    = pad_q;
  assign bus.act_mode    = act_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_conv_job_tx.sv
// Directed bench for conv_job_tx: byte memory model, engine-side monitor
// with an expected-data queue, and hand-computed timing per job.
module tb_conv_job_tx;
  import conv_pkg::*;

  localparam int TIMEOUT  = 256;
  localparam int IMG_BASE = 32;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  conv_job_tx_if #(.ADDR_W(7)) bus ();

  conv_job_tx #(
    .ADDR_W    (7),
    .FILT_BASE (0),
    .IMG_BASE  (IMG_BASE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:127];
  initial for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 11);
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_b, want_b;
  int fv_n, iv_n, fv_first, fv_last, iv_first, iv_last;
  int rd_n, busy_n, done_n, err_n, done_cyc, err_cyc, cfg_bad, overlap_n;
  logic       cfg_fs, cfg_pad, cfg_act;
  logic [3:0] cfg_n;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.filter_valid || bus.image_valid) begin
        if (bus.filter_valid && bus.image_valid) overlap_n++;
        if (bus.filter_size != cfg_fs || bus.image_size != cfg_n ||
            bus.pad_mode != cfg_pad || bus.act_mode != cfg_act) cfg_bad++;
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          want_b = exp_q.pop_front();
          got_b  = bus.in_data;
          chk("in_data", int'(got_b), int'(want_b));
        end
      end
      if (bus.filter_valid) begin
        if (fv_n == 0) fv_first = cyc;
        fv_last = cyc;
        fv_n++;
      end
      if (bus.image_valid) begin
        if (iv_n == 0) iv_first = cyc;
        iv_last = cyc;
        iv_n++;
      end
      if (bus.mem_rd) rd_n++;
      if (bus.busy)   busy_n++;
      if (bus.done) begin done_n++; done_cyc = cyc; end
      if (bus.err)  begin err_n++;  err_cyc  = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    fv_n = 0; iv_n = 0; fv_first = -1; fv_last = -1; iv_first = -1; iv_last = -1;
    rd_n = 0; busy_n = 0; done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    cfg_bad = 0; overlap_n = 0;
  endtask

  task automatic drive_start(input logic fs, input logic [3:0] n,
                             input logic pad, input logic act);
    bus.start             = 1'b1;
    bus.start_filter_size = fs;
    bus.start_image_size  = n;
    bus.start_pad_mode    = pad;
    bus.start_act_mode    = act;
  endtask

  // ov_ofs: out_valid beats sampled at edges t+ov_ofs .. t+ov_ofs+N*N-1 (0 = none).
  // exp_end: edge offset from accept at which done/err is seen.
  // extra_at: edge offset of a stray start pulse (0 = none).
  task automatic run_job(input string name, input logic fs, input logic [3:0] n,
                         input logic pad, input logic act, input int ov_ofs,
                         input bit exp_done, input int exp_end, input int extra_at);
    int  t, taps, npix, nxt;
    bit  legal;
    taps  = fs ? 25 : 9;
    npix  = int'(n) * int'(n);
    legal = (n >= 4'd3) && (n <= 4'd8);
    clear_mon();
    cfg_fs = fs; cfg_n = n; cfg_pad = pad; cfg_act = act;
    if (legal) begin
      for (int k = 0; k < taps; k++) exp_q.push_back(mem[k]);
      for (int p = 0; p < npix; p++) exp_q.push_back(mem[IMG_BASE + p]);
    end
    @(negedge clk);
    drive_start(fs, n, pad, act);
    t = cyc + 1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      nxt = cyc + 1;
      bus.start = (extra_at > 0) && (nxt == t + extra_at);
      if (bus.start) begin
        bus.start_filter_size = ~fs;
        bus.start_image_size  = 4'd5;
      end
      bus.out_valid = (ov_ofs > 0) && (nxt >= t + ov_ofs) && (nxt < t + ov_ofs + npix);
      if (done_n + err_n > 0) break;
    end
    bus.start     = 1'b0;
    bus.out_valid = 1'b0;
    repeat (3) @(negedge clk);

    chk($sformatf("%s.done_n", name), done_n, exp_done ? 1 : 0);
    chk($sformatf("%s.err_n", name), err_n, exp_done ? 0 : 1);
    chk($sformatf("%s.end_cyc", name), (exp_done ? done_cyc : err_cyc) - t, exp_end);
    chk($sformatf("%s.busy_n", name), busy_n, legal ? exp_end : 0);
    chk($sformatf("%s.rd_n", name), rd_n, legal ? taps + npix : 0);
    chk($sformatf("%s.fv_n", name), fv_n, legal ? taps : 0);
    chk($sformatf("%s.iv_n", name), iv_n, legal ? npix : 0);
    if (legal) begin
      chk($sformatf("%s.fv_first", name), fv_first - t, 3);
      chk($sformatf("%s.fv_span", name), fv_last - fv_first + 1, taps);
      chk($sformatf("%s.iv_first", name), iv_first - t, taps + 4);
      chk($sformatf("%s.iv_span", name), iv_last - iv_first + 1, npix);
    end
    chk($sformatf("%s.overlap", name), overlap_n, 0);
    chk($sformatf("%s.cfg_bad", name), cfg_bad, 0);
    chk($sformatf("%s.exp_left", name), exp_q.size(), 0);
    chk($sformatf("%s.state", name), int'(dbg_state), int'(ST_IDLE));
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    chk($sformatf("%s.busy", name), int'(bus.busy), 0);
    chk($sformatf("%s.done", name), int'(bus.done), 0);
    chk($sformatf("%s.err", name), int'(bus.err), 0);
    chk($sformatf("%s.mem_rd", name), int'(bus.mem_rd), 0);
    chk($sformatf("%s.mem_addr", name), int'(bus.mem_addr), 0);
    chk($sformatf("%s.fv", name), int'(bus.filter_valid), 0);
    chk($sformatf("%s.iv", name), int'(bus.image_valid), 0);
    chk($sformatf("%s.in_data", name), int'(bus.in_data), 0);
    chk($sformatf("%s.cfg", name),
        int'({bus.filter_size, bus.image_size, bus.pad_mode, bus.act_mode}), 0);
    chk($sformatf("%s.state", name), int'(dbg_state), int'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b1;
    bus.start = 1'b0; bus.start_filter_size = 1'b0; bus.start_image_size = '0;
    bus.start_pad_mode = 1'b0; bus.start_act_mode = 1'b0; bus.out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);

    // 3x3, N=4; stray start at t+20 (IMG) must be ignored; done at t+31
    run_job("j3x3_n4", 1'b0, 4'd4, 1'b0, 1'b0, 15, 1'b1, 31, 20);
    // 5x5, N=8, act=1; done at t+94
    run_job("j5x5_n8", 1'b1, 4'd8, 1'b0, 1'b1, 30, 1'b1, 94, 0);
    // illegal sizes: err at t+1, no reads
    run_job("bad_n2", 1'b0, 4'd2, 1'b0, 1'b0, 0, 1'b0, 1, 0);
    run_job("bad_n9", 1'b1, 4'd9, 1'b1, 1'b1, 0, 1'b0, 1, 0);
    // no results: DRAIN entered at t+19, err at t+19+TIMEOUT
    run_job("timeout", 1'b0, 4'd3, 1'b0, 1'b0, 0, 1'b0, 19 + TIMEOUT, 0);
    // all results arrive during FILT/IMG: done on first DRAIN cycle, t+20
    run_job("early_ov", 1'b0, 4'd3, 1'b1, 1'b0, 4, 1'b1, 20, 0);

    // reset in the middle of the image burst
    clear_mon();
    cfg_fs = 1'b0; cfg_n = 4'd8; cfg_pad = 1'b0; cfg_act = 1'b1;
    for (int k = 0; k < 9; k++) exp_q.push_back(mem[k]);
    for (int p = 0; p < 64; p++) exp_q.push_back(mem[IMG_BASE + p]);
    @(negedge clk);
    drive_start(1'b0, 4'd8, 1'b0, 1'b1);
    t = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("midrst.pre_iv", int'(bus.image_valid), 1);
    chk("midrst.pre_state", int'(dbg_state), int'(ST_IMG));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst.cycle", cyc - t, 21);
    run_job("after_rst", 1'b0, 4'd4, 1'b0, 1'b0, 15, 1'b1, 31, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
